// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - instruction decoder FSM that sequences load/conv/store units
//
// Accepts a 64-bit instruction word on a one-cycle instruction_enable strobe,
// decodes the opcode in ctr[63:60], and issues a single start pulse to the
// matching execution unit. It then waits for that unit's done and emits a
// one-cycle instr_exe_state pulse.
//
// Optional feature macro: DECODER_TIMEOUT_EN. When it is defined, a watchdog
// forces completion after TIMEOUT_CYCLES WAIT cycles and sets timeout_err.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   instruction_enable    ctr is valid this cycle (used only in IDLE)
//   ctr[63:0]             instruction word: opcode[63:60], addr[59:40],
//                         len[39:24], cfg[23:0]
//   instr_exe_state       one-cycle pulse when the current instruction finishes
//   load/conv/store_start one-cycle unit start pulses, at most one per cycle
//   load/conv/store_done  unit completion, level or pulse
//   ddr_addr/xfer_len/layer_cfg  fields latched from the accepted instruction
//   busy                  high in every state except IDLE
//   illegal_instr         sticky: an opcode of 4..15 was executed
//   timeout_err           sticky: watchdog expired (tied 0 without the macro)
//   instr_cnt[15:0]       completed instructions, wraps at 0xFFFF

module instr_decoder #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instruction_enable,
    input  logic [63:0] ctr,
    output logic        instr_exe_state,
    output logic        load_start,
    output logic        conv_start,
    output logic        store_start,
    input  logic        load_done,
    input  logic        conv_done,
    input  logic        store_done,
    output logic [19:0] ddr_addr,
    output logic [15:0] xfer_len,
    output logic [23:0] layer_cfg,
    output logic        busy,
    output logic        illegal_instr,
    output logic        timeout_err,
    output logic [15:0] instr_cnt
);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_CONV  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      state_q;
    logic [3:0]  opcode_q;
    logic [19:0] ddr_addr_q;
    logic [15:0] xfer_len_q;
    logic [23:0] layer_cfg_q;
    logic        load_start_q;
    logic        conv_start_q;
    logic        store_start_q;
    logic        exe_pulse_q;
    logic        illegal_q;
    logic [15:0] instr_cnt_q;
    logic        active_done;
    logic        opcode_is_unit;

    // Only the unit selected by the latched opcode may end the WAIT state.
    always_comb begin
        active_done = 1'b0;
        case (opcode_q)
            OP_LOAD:  active_done = load_done;
            OP_CONV:  active_done = conv_done;
            OP_STORE: active_done = store_done;
            default:  active_done = 1'b0;
        endcase
    end

    assign opcode_is_unit = (opcode_q == OP_LOAD) || (opcode_q == OP_CONV) ||
                            (opcode_q == OP_STORE);

`ifdef DECODER_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt_q;
    logic          timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            opcode_q      <= OP_NOP;
            ddr_addr_q    <= '0;
            xfer_len_q    <= '0;
            layer_cfg_q   <= '0;
            load_start_q  <= 1'b0;
            conv_start_q  <= 1'b0;
            store_start_q <= 1'b0;
            exe_pulse_q   <= 1'b0;
            illegal_q     <= 1'b0;
            instr_cnt_q   <= '0;
`ifdef DECODER_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            // Pulse outputs are asserted only on the edge entering their state.
            load_start_q  <= 1'b0;
            conv_start_q  <= 1'b0;
            store_start_q <= 1'b0;
            exe_pulse_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (instruction_enable) begin
                        opcode_q    <= ctr[63:60];
                        ddr_addr_q  <= ctr[59:40];
                        xfer_len_q  <= ctr[39:24];
                        layer_cfg_q <= ctr[23:0];
                        state_q     <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (opcode_is_unit) begin
                        load_start_q  <= (opcode_q == OP_LOAD);
                        conv_start_q  <= (opcode_q == OP_CONV);
                        store_start_q <= (opcode_q == OP_STORE);
                        state_q       <= S_ISSUE;
                    end else begin
                        // NOP and illegal opcodes both complete without a unit.
                        exe_pulse_q <= 1'b1;
                        instr_cnt_q <= instr_cnt_q + 16'd1;
                        if (opcode_q != OP_NOP) begin
                            illegal_q <= 1'b1;
                        end
                        state_q <= S_DONE;
                    end
                end

                S_ISSUE: begin
                    // A done seen here belongs to no issued command yet; ignore it.
`ifdef DECODER_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (active_done) begin
                        exe_pulse_q <= 1'b1;
                        instr_cnt_q <= instr_cnt_q + 16'd1;
                        state_q     <= S_DONE;
`ifdef DECODER_TIMEOUT_EN
                    end else if (wait_cnt_q == WAIT_LIMIT) begin
                        exe_pulse_q <= 1'b1;
                        instr_cnt_q <= instr_cnt_q + 16'd1;
                        timeout_q   <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_exe_state = exe_pulse_q;
    assign load_start      = load_start_q;
    assign conv_start      = conv_start_q;
    assign store_start     = store_start_q;
    assign ddr_addr        = ddr_addr_q;
    assign xfer_len        = xfer_len_q;
    assign layer_cfg       = layer_cfg_q;
    assign busy            = (state_q != S_IDLE);
    assign illegal_instr   = illegal_q;
    assign instr_cnt       = instr_cnt_q;

`ifdef DECODER_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// tb/tb_instr_decoder.sv - scoreboard testbench for instr_decoder

module tb_instr_decoder;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        instruction_enable;
    logic [63:0] ctr;
    logic        instr_exe_state;
    logic        load_start, conv_start, store_start;
    logic        load_done, conv_done, store_done;
    logic [19:0] ddr_addr;
    logic [15:0] xfer_len;
    logic [23:0] layer_cfg;
    logic        busy;
    logic        illegal_instr;
    logic        timeout_err;
    logic [15:0] instr_cnt;

    always #5 clk = ~clk;

    instr_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                (clk),
        .rst                (rst),
        .instruction_enable (instruction_enable),
        .ctr                (ctr),
        .instr_exe_state    (instr_exe_state),
        .load_start         (load_start),
        .conv_start         (conv_start),
        .store_start        (store_start),
        .load_done          (load_done),
        .conv_done          (conv_done),
        .store_done         (store_done),
        .ddr_addr           (ddr_addr),
        .xfer_len           (xfer_len),
        .layer_cfg          (layer_cfg),
        .busy               (busy),
        .illegal_instr      (illegal_instr),
        .timeout_err        (timeout_err),
        .instr_cnt          (instr_cnt)
    );

    typedef struct {
        logic [1:0]  kind;
        int          pulse_cyc;
        logic [15:0] cnt;
        logic        illegal;
        logic        tmo;
        logic [19:0] ddr;
        logic [15:0] xfer;
        logic [23:0] cfg;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_cnt = '0;
    logic        m_ill = 1'b0;
    logic        m_tmo = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        instruction_enable = 1'b0;
        load_done  = 1'b0;
        conv_done  = 1'b0;
        store_done = 1'b0;
    endtask

    task automatic model_reset();
        m_cnt = '0;
        m_ill = 1'b0;
        m_tmo = 1'b0;
        sb.delete();
    endtask

    // delay: cycles from the start pulse to the active done (<0: never).
    // noise: fire the active done during ISSUE, plus foreign dones and new
    // enables with a different word while waiting.
    task automatic run_instr(input logic [63:0] word, input int delay,
                             input bit noise, input bit expect_tmo);
        exp_t        e;
        exp_t        got_e;
        int          op;
        int          cyc;
        int          start_cyc;
        int          nstarts;
        int          pulse_cyc;
        logic [1:0]  start_kind;
        logic        act;
        logic        other;
        op = int'(word[63:60]);
        e.kind = (op >= 1 && op <= 3) ? 2'(op) : 2'd0;
        m_cnt = m_cnt + 16'd1;
        if (op > 3) m_ill = 1'b1;
        if (expect_tmo) m_tmo = 1'b1;
        e.cnt = m_cnt;
        e.illegal = m_ill;
        e.tmo = m_tmo;
        e.ddr = word[59:40];
        e.xfer = word[39:24];
        e.cfg = word[23:0];
        if (e.kind == 2'd0) e.pulse_cyc = 2;
        else if (expect_tmo) e.pulse_cyc = 3 + TMO;
        else e.pulse_cyc = 3 + delay;
        sb.push_back(e);

        cyc = 0; start_cyc = -1; nstarts = 0; pulse_cyc = -1; start_kind = 2'd0;
        @(posedge clk); #1;
        instruction_enable = 1'b1;
        ctr = word;
        while (pulse_cyc < 0 && cyc < 200) begin
            @(negedge clk);
            if (load_start)  begin nstarts++; start_kind = 2'd1; start_cyc = cyc; end
            if (conv_start)  begin nstarts++; start_kind = 2'd2; start_cyc = cyc; end
            if (store_start) begin nstarts++; start_kind = 2'd3; start_cyc = cyc; end
            if (instr_exe_state) begin
                pulse_cyc = cyc;
                check("busy_in_done", {63'd0, busy}, 64'd1);
            end
            @(posedge clk); #1;
            cyc++;
            instruction_enable = 1'b0;
            act = ((delay >= 0) && (cyc == 2 + delay)) || (noise && cyc == 2);
            other = noise && (cyc >= 3) && (delay < 0 || cyc < 2 + delay);
            load_done  = (e.kind == 2'd1) ? act : other;
            conv_done  = (e.kind == 2'd2) ? act : other;
            store_done = (e.kind == 2'd3) ? act : other;
            if (other) begin
                instruction_enable = 1'b1;
                ctr = {4'd3, ~word[59:0]};
            end
        end
        clear_inputs();
        if (pulse_cyc < 0) check("pulse_never_seen", 64'd0, 64'd1);
        @(negedge clk);
        check("pulse_width", {63'd0, instr_exe_state}, 64'd0);
        check("idle_after_done", {63'd0, busy}, 64'd0);

        got_e = sb.pop_front();
        check("start_count", 64'(nstarts), (got_e.kind == 2'd0) ? 64'd0 : 64'd1);
        check("start_kind", {62'd0, start_kind}, {62'd0, got_e.kind});
        if (got_e.kind != 2'd0) check("start_cycle", 64'(start_cyc), 64'd2);
        check("pulse_cycle", 64'(pulse_cyc), 64'(got_e.pulse_cyc));
        check("instr_cnt", {48'd0, instr_cnt}, {48'd0, got_e.cnt});
        check("illegal_instr", {63'd0, illegal_instr}, {63'd0, got_e.illegal});
        check("timeout_err", {63'd0, timeout_err}, {63'd0, got_e.tmo});
        check("ddr_addr", {44'd0, ddr_addr}, {44'd0, got_e.ddr});
        check("xfer_len", {48'd0, xfer_len}, {48'd0, got_e.xfer});
        check("layer_cfg", {40'd0, layer_cfg}, {40'd0, got_e.cfg});
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_pulse"}, {63'd0, instr_exe_state}, 64'd0);
        check({tag, "_starts"}, {61'd0, load_start, conv_start, store_start}, 64'd0);
        check({tag, "_cnt"}, {48'd0, instr_cnt}, 64'd0);
        check({tag, "_illegal"}, {63'd0, illegal_instr}, 64'd0);
        check({tag, "_timeout"}, {63'd0, timeout_err}, 64'd0);
        check({tag, "_fields"}, {4'd0, ddr_addr, xfer_len, layer_cfg}, 64'd0);
    endtask

    initial begin
        logic [63:0] w;
        int          seen;
        rst = 1'b1;
        ctr = '0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset");

        // Reference LOAD with done five cycles after start.
        run_instr(64'h1000_0A00_0100_0000, 5, 1'b0, 1'b0);
        check("ref_ddr_addr", {44'd0, ddr_addr}, 64'h0000A);
        check("ref_xfer_len", {48'd0, xfer_len}, 64'h0001);
        check("ref_cnt", {48'd0, instr_cnt}, 64'd1);

        run_instr(64'h0, 0, 1'b0, 1'b0);
        run_instr(64'h2123_4567_89AB_CDEF, 3, 1'b0, 1'b0);
        run_instr(64'h3FED_CBA9_8765_4321, 1, 1'b0, 1'b0);
        run_instr(64'h7000_0000_0000_0055, 0, 1'b0, 1'b0);
        run_instr(64'h1ABC_DE00_2000_0042, 2, 1'b0, 1'b0);
        run_instr(64'hF000_0000_0000_0000, 0, 1'b0, 1'b0);
        run_instr(64'h2055_5AAA_A123_4567, 6, 1'b1, 1'b0);

        // Reset while a STORE sits in WAIT.
        @(posedge clk); #1;
        instruction_enable = 1'b1;
        ctr = 64'h3000_1000_2000_3000;
        @(posedge clk); #1;
        instruction_enable = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_reset_state("mid_reset");
        @(negedge clk);
        check("post_reset_pulse", {60'd0, instr_exe_state, load_start, conv_start, store_start}, 64'd0);
        run_instr(64'h1000_0A00_0100_0000, 4, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            w = {$urandom, $urandom};
            w[63:60] = 4'($urandom_range(0, 4));
            run_instr(w, int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef DECODER_TIMEOUT_EN
        run_instr(64'h1000_0000_0000_0001, -1, 1'b0, 1'b1);
        run_instr(64'h2000_0000_0000_0002, 2, 1'b0, 1'b0);
`else
        @(posedge clk); #1;
        instruction_enable = 1'b1;
        ctr = 64'h1000_0000_0000_0001;
        @(posedge clk); #1;
        instruction_enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 3 * TMO; i++) begin
            @(negedge clk);
            if (instr_exe_state) seen++;
        end
        check("hold_no_pulse", 64'(seen), 64'd0);
        check("hold_busy", {63'd0, busy}, 64'd1);
        check("hold_timeout_err", {63'd0, timeout_err}, 64'd0);
        do_reset();
        check_reset_state("final_reset");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: WAIT-state watchdog limit in cycles; used only when DECODER_TIMEOUT_EN is defined.
REQ-002 clk  in  1  clock; all logic on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 instruction_enable  in  1  one-cycle strobe from top FSM: ctr valid this cycle.
REQ-005 ctr  in  64  instruction word.
REQ-006 instr_exe_state  out  1  one-cycle pulse: current instruction finished.
REQ-007 load_start / conv_start / store_start  out  1 each  one-cycle unit start pulses.
REQ-008 load_done / conv_done / store_done  in  1 each  unit completion, level or pulse.
REQ-009 ddr_addr  out  20  ctr[59:40], registered.
REQ-010 xfer_len  out  16  ctr[39:24], registered.
REQ-011 layer_cfg  out  24  ctr[23:0], registered.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 illegal_instr  out  1  sticky illegal-opcode flag.
REQ-014 timeout_err  out  1  sticky watchdog flag.
REQ-015 instr_cnt  out  16  completed instructions, wraps 0xFFFF->0.

Function
REQ-016 Opcode = ctr[63:60]: 0 NOP, 1 LOAD, 2 CONV, 3 STORE; 4-15 illegal.
REQ-017 States: IDLE, DECODE, ISSUE, WAIT, DONE; one-hot or binary, implementer's choice.
REQ-018 IDLE: instruction_enable=1 at edge T -> latch opcode and fields; DECODE during cycle T+1.
REQ-019 DECODE: LOAD/CONV/STORE -> ISSUE; NOP or illegal -> DONE.
REQ-020 ISSUE: exactly one matching *_start high for one cycle, then WAIT.
REQ-021 WAIT: only the active unit's done is sampled; done=1 -> DONE next cycle.
REQ-022 DONE: instr_exe_state=1 for exactly this cycle; instr_cnt+1; then IDLE.
REQ-023 Latency: NOP pulse 2 cycles after enable cycle; LOAD/CONV/STORE pulse 1 cycle after done sampled in WAIT.
REQ-024 Illegal opcode: processed as NOP; illegal_instr set in DONE cycle; held until reset.
REQ-025 instruction_enable outside IDLE: ignored; latched fields unchanged.
REQ-026 done during ISSUE or from a non-active unit: ignored.
REQ-027 ddr_addr, xfer_len, layer_cfg stable from DECODE until next accepted instruction.
REQ-028 At most one *_start high in any cycle.

Reset
REQ-029 rst=1: state IDLE; all outputs 0, including instr_cnt, sticky flags and fields.
REQ-030 rst mid-instruction: abort, no instr_exe_state pulse, no start pulse on the cycle following reset.

Configuration
REQ-031 DECODER_TIMEOUT_EN defined: WAIT cycle counter cleared on WAIT entry; TIMEOUT_CYCLES WAIT cycles without done -> DONE (normal pulse, instr_cnt+1), timeout_err set (sticky).
REQ-032 DECODER_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; timeout_err tied 0; port list unchanged.

Verification
REQ-033 ctr=0x1000_0A00_0100_0000 with enable, load_done 5 cycles after load_start -> load_start 1 cycle; ddr_addr=0x0000A, xfer_len=0x0001; instr_exe_state 1 cycle; instr_cnt=1.
REQ-034 NOP (ctr=0) at cycle 0 -> instr_exe_state in cycle 2; no start pulse; illegal_instr=0.
REQ-035 Opcode 0x7 -> no start pulse; pulse in cycle 2; illegal_instr=1 through later valid instructions until rst.
REQ-036 CONV in WAIT, conv_done held 0, load_done pulsed, second instruction_enable -> no transition; conv_done then completes normally.
REQ-037 rst asserted during WAIT of STORE -> busy=0, instr_cnt=0, no pulse; next LOAD executes normally.
REQ-038 With DECODER_TIMEOUT_EN, TIMEOUT_CYCLES=16, LOAD with no done -> pulse after 16 WAIT cycles; timeout_err=1. Without macro -> busy stays 1; timeout_err=0.
